// File: rtl/sw_evt_trig_timed_if.sv
// Peripheral bus port of the software event trigger unit: request side plus
// the registered response channel.
interface sw_evt_trig_timed_if #(
  parameter int ID_W = 5
);
  logic            req_i;
  logic [31:0]     add_i;
  logic            we_n_i;
  logic [31:0]     wdata_i;
  logic [3:0]      be_i;
  logic [ID_W-1:0] id_i;
  logic            gnt_o;
  logic            r_valid_o;
  logic [31:0]     r_rdata_o;
  logic [ID_W-1:0] r_id_o;
  logic            r_opc_o;

  modport master (
    output req_i, add_i, we_n_i, wdata_i, be_i, id_i,
    input  gnt_o, r_valid_o, r_rdata_o, r_id_o, r_opc_o
  );

  modport slave (
    input  req_i, add_i, we_n_i, wdata_i, be_i, id_i,
    output gnt_o, r_valid_o, r_rdata_o, r_id_o, r_opc_o
  );
endinterface

// File: rtl/sw_evt_trig_timed.sv
// Software event trigger: immediate or delayed event pulses to a set of cores,
// one countdown channel per event, all state readable over the peripheral bus.
module sw_evt_trig_timed #(
  parameter int NB_CORES  = 8,
  parameter int NB_SW_EVT = 8,
  parameter int CNT_W     = 16,
  parameter int ID_W      = 5
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  sw_evt_trig_timed_if.slave                   bus,
  output logic [NB_CORES-1:0][NB_SW_EVT-1:0]   sw_events_o
);

  typedef enum logic {IDLE, ARMED} state_e;

  state_e              state_q [NB_SW_EVT];
  state_e              state_d [NB_SW_EVT];
  logic [CNT_W-1:0]    cnt_q   [NB_SW_EVT];
  logic [CNT_W-1:0]    cnt_d   [NB_SW_EVT];
  logic [NB_CORES-1:0] mask_q  [NB_SW_EVT];
  logic [NB_CORES-1:0] mask_d  [NB_SW_EVT];

  logic [NB_CORES-1:0][NB_SW_EVT-1:0] sw_events_q, sw_events_d;

  logic            r_valid_q, r_valid_d;
  logic [31:0]     r_rdata_q, r_rdata_d;
  logic [ID_W-1:0] r_id_q, r_id_d;
  logic            r_opc_q, r_opc_d;

  logic [2:0]           evt;
  logic [1:0]           region;
  logic                 evt_ok;
  logic                 wr;
  logic                 rd;
  logic [NB_SW_EVT-1:0] armed;
  logic                 unused_bits;

  assign evt    = bus.add_i[4:2];
  assign region = bus.add_i[6:5];
  assign evt_ok = int'(evt) < NB_SW_EVT;
  assign wr     = bus.req_i && !bus.we_n_i;
  assign rd     = bus.req_i && bus.we_n_i;

  assign bus.gnt_o     = bus.req_i;
  assign bus.r_valid_o = r_valid_q;
  assign bus.r_rdata_o = r_rdata_q;
  assign bus.r_id_o    = r_id_q;
  assign bus.r_opc_o   = r_opc_q;
  assign sw_events_o   = sw_events_q;

  assign unused_bits = ^{bus.be_i, bus.add_i, bus.wdata_i};

  // An all-zero target mask addresses every core.
  function automatic logic [NB_CORES-1:0] expand(input logic [NB_CORES-1:0] m);
    return (m == '0) ? '1 : m;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    sw_events_d = '0;
    r_rdata_d   = '0;
    armed       = '0;
    r_valid_d   = bus.req_i;
    r_id_d      = bus.req_i ? bus.id_i : '0;
    r_opc_d     = bus.req_i && (region != 2'b11) && !evt_ok;

    for (int i = 0; i < NB_SW_EVT; i++) begin
      logic                hit;
      logic                delayed_fire;
      logic [NB_CORES-1:0] tgt;
      hit          = evt == 3'(i);
      delayed_fire = 1'b0;
      tgt          = '0;
      armed[i]     = state_q[i] == ARMED;

      if (state_q[i] == ARMED) begin
        if (cnt_q[i] == CNT_W'(1)) begin
          delayed_fire = 1'b1;
          state_d[i]   = IDLE;
          cnt_d[i]     = '0;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end

      // A DELAY write overrides whatever the countdown would have done this cycle.
      if (wr && hit) begin
        case (region)
          2'b00: tgt = expand(bus.wdata_i[NB_CORES-1:0]);
          2'b01: mask_d[i] = bus.wdata_i[NB_CORES-1:0];
          2'b10: begin
            delayed_fire = 1'b0;
            state_d[i]   = IDLE;
            cnt_d[i]     = '0;
            if (!bus.wdata_i[31]) begin
              if (bus.wdata_i[CNT_W-1:0] == '0) begin
                tgt = expand(mask_q[i]);
              end else begin
                state_d[i] = ARMED;
                cnt_d[i]   = bus.wdata_i[CNT_W-1:0];
              end
            end
          end
          default: ;
        endcase
      end

      // Delayed fires see the mask as it stands in the cycle the pulse appears.
      if (delayed_fire) begin
        tgt = tgt | expand(mask_d[i]);
      end

      for (int c = 0; c < NB_CORES; c++) begin
        sw_events_d[c][i] = tgt[c];
      end

      if (rd && hit) begin
        case (region)
          2'b01:   r_rdata_d = 32'(mask_q[i]);
          2'b10:   r_rdata_d = 32'(cnt_q[i]);
          default: ;
        endcase
      end
    end

    if (rd && region == 2'b11) begin
      r_rdata_d = 32'(armed);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_SW_EVT; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        mask_q[i]  <= '0;
      end
      sw_events_q <= '0;
      r_valid_q   <= 1'b0;
      r_rdata_q   <= '0;
      r_id_q      <= '0;
      r_opc_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NB_SW_EVT; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        mask_q[i]  <= mask_d[i];
      end
      sw_events_q <= sw_events_d;
      r_valid_q   <= r_valid_d;
      r_rdata_q   <= r_rdata_d;
      r_id_q      <= r_id_d;
      r_opc_q     <= r_opc_d;
    end
  end

endmodule

// File: tb/tb_sw_evt_trig_timed.sv
// Directed bench for sw_evt_trig_timed with six events, so event indices 6 and
// 7 exercise the error response.
module tb_sw_evt_trig_timed;

  localparam int NC = 8;
  localparam int NE = 6;

  logic clk;
  logic rst;
  logic [NC-1:0][NE-1:0] sw_events;

  int checks;
  int failures;

  sw_evt_trig_timed_if #(.ID_W(5)) bus_if ();

  sw_evt_trig_timed #(
    .NB_CORES  (NC),
    .NB_SW_EVT (NE),
    .CNT_W     (16),
    .ID_W      (5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus_if),
    .sw_events_o (sw_events)
  );

  always #5 clk = ~clk;

  // One-hot view of the flattened [core][event] pulse vector.
  function automatic logic [NC*NE-1:0] ev(input int core, input int evt);
    logic [NC*NE-1:0] v;
    v = '0;
    v[core*NE+evt] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC*NE-1:0] allCores(input int evt);
    logic [NC*NE-1:0] v;
    v = '0;
    for (int c = 0; c < NC; c++) v[c*NE+evt] = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Presents one request in the coming cycle and returns mid-way through the next.
  task automatic applyStimulus(input logic we_n, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] id);
    bus_if.req_i   = 1'b1;
    bus_if.we_n_i  = we_n;
    bus_if.add_i   = addr;
    bus_if.wdata_i = wdata;
    bus_if.id_i    = id;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    bus_if.req_i   = 1'b0;
    bus_if.we_n_i  = 1'b1;
    bus_if.add_i   = '0;
    bus_if.wdata_i = '0;
    bus_if.id_i    = '0;
    @(negedge clk);
  endtask

  task automatic checkEvents(input string tag, input logic [NC*NE-1:0] exp);
    checkOutput(tag, 64'(sw_events), 64'(exp));
  endtask

  task automatic checkResp(input string tag, input logic [31:0] rdata, input logic opc);
    checkOutput({tag, "_valid"}, 64'(bus_if.r_valid_o), 64'(1));
    checkOutput({tag, "_rdata"}, 64'(bus_if.r_rdata_o), 64'(rdata));
    checkOutput({tag, "_opc"},   64'(bus_if.r_opc_o),   64'(opc));
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    clk            = 1'b0;
    rst            = 1'b1;
    bus_if.req_i   = 1'b0;
    bus_if.we_n_i  = 1'b1;
    bus_if.add_i   = '0;
    bus_if.wdata_i = '0;
    bus_if.be_i    = 4'hF;
    bus_if.id_i    = '0;

    // Reset held for three cycles, then the first cycle out of reset.
    repeat (3) @(negedge clk);
    checkEvents("rst_events", '0);
    checkOutput("rst_valid", 64'(bus_if.r_valid_o), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    checkEvents("post_rst_events", '0);
    checkOutput("post_rst_valid", 64'(bus_if.r_valid_o), 64'(0));
    applyStimulus(1'b1, 32'h60, 32'h0, 5'd0);
    checkResp("rst_status", 32'h0, 1'b0);
    idleCycle();
    checkOutput("idle_valid", 64'(bus_if.r_valid_o), 64'(0));

    // Immediate trigger on event 3, explicit mask then all-cores.
    applyStimulus(1'b0, 32'h0C, 32'h05, 5'd2);
    checkEvents("trig_mask5", ev(0, 3) | ev(2, 3));
    checkResp("trig_resp", 32'h0, 1'b0);
    idleCycle();
    checkEvents("trig_done", '0);
    applyStimulus(1'b0, 32'h0C, 32'h00, 5'd0);
    checkEvents("trig_all", allCores(3));
    idleCycle();
    checkEvents("trig_all_done", '0);
    applyStimulus(1'b1, 32'h0C, 32'h0, 5'd0);
    checkResp("trig_read", 32'h0, 1'b0);

    // Delayed trigger: MASK[1]=0x80, DELAY[1]=10 written at cycle t.
    applyStimulus(1'b0, 32'h24, 32'h80, 5'd0);
    applyStimulus(1'b0, 32'h44, 32'd10, 5'd0);
    checkEvents("dly_t1", '0);
    idleCycle();
    checkEvents("dly_t2", '0);
    idleCycle();
    checkEvents("dly_t3", '0);
    applyStimulus(1'b1, 32'h60, 32'h0, 5'd0);
    checkResp("dly_status", 32'h02, 1'b0);
    applyStimulus(1'b1, 32'h44, 32'h0, 5'd0);
    checkResp("dly_count", 32'd7, 1'b0);
    for (int k = 5; k <= 11; k++) begin
      idleCycle();
      checkEvents($sformatf("dly_t%0d", k + 1), (k + 1 == 11) ? ev(7, 1) : '0);
    end
    idleCycle();
    checkEvents("dly_after", '0);
    applyStimulus(1'b1, 32'h60, 32'h0, 5'd0);
    checkResp("dly_status_idle", 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h44, 32'h0, 5'd0);
    checkResp("dly_count_idle", 32'h0, 1'b0);

    // Re-arm DELAY[2] from 20 to 5: only the new countdown fires.
    applyStimulus(1'b0, 32'h48, 32'd20, 5'd0);
    repeat (3) idleCycle();
    applyStimulus(1'b0, 32'h48, 32'd5, 5'd0);
    checkEvents("rearm_t1", '0);
    for (int k = 1; k <= 24; k++) begin
      idleCycle();
      checkEvents($sformatf("rearm_t%0d", k + 1), (k + 1 == 6) ? allCores(2) : '0);
    end

    // Cancel DELAY[4]=8 one cycle before it would fire.
    applyStimulus(1'b0, 32'h50, 32'd8, 5'd0);
    for (int k = 1; k <= 6; k++) idleCycle();
    applyStimulus(1'b0, 32'h50, 32'h8000_0000, 5'd0);
    checkResp("cancel_resp", 32'h0, 1'b0);
    for (int k = 8; k <= 12; k++) begin
      idleCycle();
      checkEvents($sformatf("cancel_t%0d", k + 1), '0);
    end
    applyStimulus(1'b1, 32'h60, 32'h0, 5'd0);
    checkResp("cancel_status", 32'h0, 1'b0);

    // DELAY of 0 fires next cycle using the stored mask (MASK[1]=0x80).
    applyStimulus(1'b0, 32'h44, 32'd0, 5'd0);
    checkEvents("dly0_fire", ev(7, 1));

    // Collision of a delayed fire and a TRIG write on event 0.
    applyStimulus(1'b0, 32'h20, 32'h01, 5'd0);
    applyStimulus(1'b0, 32'h40, 32'd3, 5'd0);
    checkEvents("coll_t1", '0);
    idleCycle();
    checkEvents("coll_t2", '0);
    idleCycle();
    checkEvents("coll_t3", '0);
    applyStimulus(1'b0, 32'h00, 32'h02, 5'd0);
    checkEvents("coll_t4", ev(0, 0) | ev(1, 0));
    idleCycle();
    checkEvents("coll_t5", '0);

    // Out-of-range events report an error and have no effect.
    applyStimulus(1'b0, 32'h1C, 32'hFF, 5'd3);
    checkEvents("err_trig_events", '0);
    checkResp("err_trig", 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h58, 32'h0, 5'd0);
    checkResp("err_dly_read", 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h7C, 32'hFFFF_FFFF, 5'd0);
    checkResp("status_write", 32'h0, 1'b0);
    idleCycle();
    checkEvents("err_no_events", '0);

    // Back-to-back reads with ids 1..4.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'h24, 32'h0, 5'(i));
      checkResp($sformatf("b2b_%0d", i), 32'h80, 1'b0);
      checkOutput($sformatf("b2b_id_%0d", i), 64'(bus_if.r_id_o), 64'(i));
    end
    idleCycle();
    checkOutput("b2b_end_valid", 64'(bus_if.r_valid_o), 64'(0));

    // Reset during a countdown clears it without a pulse.
    applyStimulus(1'b0, 32'h4C, 32'd5, 5'd0);
    idleCycle();
    rst = 1'b1;
    idleCycle();
    idleCycle();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idleCycle();
      checkEvents($sformatf("rst_mid_%0d", k), '0);
    end
    applyStimulus(1'b1, 32'h60, 32'h0, 5'd0);
    checkResp("rst_mid_status", 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h24, 32'h0, 5'd0);
    checkResp("rst_mid_mask", 32'h0, 1'b0);
    idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
